// File: rtl/if_id_stage_if.sv
// IF/ID boundary bus: fetch inputs, EX hazard feedback, decode-side outputs.
interface if_id_stage_if;
  logic [15:0] F_Instr;
  logic [15:0] F_Nxt_Pc;
  logic        Br_taken;
  logic        X_MemRead;
  logic [3:0]  X_Destination;
  logic [15:0] D_Instr;
  logic [15:0] D_Nxt_Pc;
  logic        D_valid;
  logic        pc_wen;
  logic        id_ex_bubble;
  logic        halted;
  logic [15:0] stall_cnt;

  modport master (
    output F_Instr, F_Nxt_Pc, Br_taken, X_MemRead, X_Destination,
    input  D_Instr, D_Nxt_Pc, D_valid, pc_wen, id_ex_bubble, halted, stall_cnt
  );

  modport slave (
    input  F_Instr, F_Nxt_Pc, Br_taken, X_MemRead, X_Destination,
    output D_Instr, D_Nxt_Pc, D_valid, pc_wen, id_ex_bubble, halted, stall_cnt
  );
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall, branch flush and HLT freeze.
module if_id_stage #(
  parameter logic [3:0]  HLT_OP    = 4'hF,
  parameter logic [3:0]  LW_OP     = 4'h8,
  parameter logic [3:0]  SW_OP     = 4'h9,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic         clk,
  input  logic         rst_n,
  if_id_stage_if.slave bus
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t      r_state;
  logic [15:0] r_instr;
  logic [15:0] r_nxt_pc;
  logic        r_valid;
  logic [15:0] r_stall_cnt;

  logic [3:0]  w_op;
  logic [3:0]  w_src1;
  logic [3:0]  w_src2;
  logic        w_hz;
  logic        w_halt;
  logic        w_stall;
  logic        w_is_lw;

  assign w_op   = r_instr[15:12];
  assign w_src1 = r_instr[7:4];
  // SW and opcodes A/B read their second source from the rd field
  assign w_src2 = (w_op == SW_OP || w_op == 4'hA || w_op == 4'hB) ? r_instr[11:8]
                                                                  : r_instr[3:0];
  // opcode in decode is a load; X_MemRead alone drives the hazard
  assign w_is_lw = (w_op == LW_OP);

  // R0 is hardwired zero, so a load into it never creates a dependency
  assign w_hz = r_valid & bus.X_MemRead & (bus.X_Destination != 4'd0) &
                ((bus.X_Destination == w_src1) | (bus.X_Destination == w_src2));

  assign w_halt  = (r_state == S_HALT);
  // flush wins over a simultaneous hazard
  assign w_stall = ~w_halt & ~bus.Br_taken & w_hz;

  assign bus.D_Instr      = r_instr;
  assign bus.D_Nxt_Pc     = r_nxt_pc;
  assign bus.D_valid      = r_valid;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.halted       = w_halt;
  assign bus.pc_wen       = ~w_halt & ~w_stall;
  assign bus.id_ex_bubble = w_halt | w_stall;

  // IF/ID register, halt FSM and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_instr     <= NOP_INSTR;
      r_nxt_pc    <= 16'h0000;
      r_valid     <= 1'b0;
      r_stall_cnt <= 16'h0000;
    end else begin
      case (r_state)
        S_HALT: begin
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
        end
        default: begin
          if (bus.Br_taken) begin
            r_instr  <= NOP_INSTR;
            r_valid  <= 1'b0;
            r_nxt_pc <= bus.F_Nxt_Pc;
          end else if (w_hz) begin
            if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
          end else if (r_valid && w_op == HLT_OP) begin
            // HLT goes on to ID/EX this cycle; fetch freezes behind it
            r_state <= S_HALT;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end else begin
            r_instr  <= bus.F_Instr;
            r_nxt_pc <= bus.F_Nxt_Pc;
            r_valid  <= 1'b1;
          end
        end
      endcase
    end
  end

  // w_is_lw is kept for decode visibility only
  logic w_unused;
  assign w_unused = w_is_lw;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage.
module tb_if_id_stage;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [15:0] exp_cnt;

  if_id_stage_if bus ();

  if_id_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    // not used as a shared checker; kept out of the comparison path
  endtask

  task automatic drive(input logic [15:0] ins, input logic [15:0] pc, input logic br,
                       input logic mr, input logic [3:0] dst);
    bus.F_Instr = ins; bus.F_Nxt_Pc = pc; bus.Br_taken = br;
    bus.X_MemRead = mr; bus.X_Destination = dst;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 4'd0);
    #12;
    total++; if (bus.D_Instr !== 16'h0000) begin bad++; $display("FAIL rst_instr act=%h exp=0000", bus.D_Instr); end
    total++; if (bus.D_Nxt_Pc !== 16'h0000) begin bad++; $display("FAIL rst_pc act=%h exp=0000", bus.D_Nxt_Pc); end
    total++; if (bus.D_valid !== 1'b0) begin bad++; $display("FAIL rst_valid act=%b exp=0", bus.D_valid); end
    total++; if (bus.pc_wen !== 1'b1) begin bad++; $display("FAIL rst_pcwen act=%b exp=1", bus.pc_wen); end
    total++; if (bus.id_ex_bubble !== 1'b0) begin bad++; $display("FAIL rst_bubble act=%b exp=0", bus.id_ex_bubble); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL rst_halted act=%b exp=0", bus.halted); end
    total++; if (bus.stall_cnt !== 16'h0000) begin bad++; $display("FAIL rst_cnt act=%h exp=0000", bus.stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 16'h0000;
  endtask

  task automatic test_load();
    drive(16'h1234, 16'h0002, 1'b0, 1'b0, 4'd0);
    step();
    total++; if (bus.D_Instr !== 16'h1234) begin bad++; $display("FAIL load_instr act=%h exp=1234", bus.D_Instr); end
    total++; if (bus.D_Nxt_Pc !== 16'h0002) begin bad++; $display("FAIL load_pc act=%h exp=0002", bus.D_Nxt_Pc); end
    total++; if (bus.D_valid !== 1'b1) begin bad++; $display("FAIL load_valid act=%b exp=1", bus.D_valid); end
    total++; if (bus.pc_wen !== 1'b1) begin bad++; $display("FAIL load_pcwen act=%b exp=1", bus.pc_wen); end
  endtask

  task automatic test_hazard();
    drive(16'h0312, 16'h0004, 1'b0, 1'b0, 4'd0);
    step();
    drive(16'h5555, 16'h0006, 1'b0, 1'b1, 4'd1);
    #1;
    total++; if (bus.pc_wen !== 1'b0) begin bad++; $display("FAIL hz_pcwen act=%b exp=0", bus.pc_wen); end
    total++; if (bus.id_ex_bubble !== 1'b1) begin bad++; $display("FAIL hz_bubble act=%b exp=1", bus.id_ex_bubble); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    total++; if (bus.D_Instr !== 16'h0312) begin bad++; $display("FAIL hz_hold act=%h exp=0312", bus.D_Instr); end
    total++; if (bus.stall_cnt !== exp_cnt) begin bad++; $display("FAIL hz_cnt act=%h exp=%h", bus.stall_cnt, exp_cnt); end
    // rt field match (src2 = [3:0] = 2)
    bus.X_Destination = 4'd2;
    #1;
    total++; if (bus.pc_wen !== 1'b0) begin bad++; $display("FAIL hz_rt_pcwen act=%b exp=0", bus.pc_wen); end
    // unrelated destination: no stall
    bus.X_Destination = 4'd7;
    #1;
    total++; if (bus.id_ex_bubble !== 1'b0) begin bad++; $display("FAIL hz_miss_bubble act=%b exp=0", bus.id_ex_bubble); end
    // R0 destination never stalls
    bus.X_Destination = 4'd0;
    #1;
    total++; if (bus.pc_wen !== 1'b1) begin bad++; $display("FAIL hz_r0_pcwen act=%b exp=1", bus.pc_wen); end
    total++; if (bus.id_ex_bubble !== 1'b0) begin bad++; $display("FAIL hz_r0_bubble act=%b exp=0", bus.id_ex_bubble); end
    step();
    total++; if (bus.D_Instr !== 16'h5555) begin bad++; $display("FAIL hz_r0_adv act=%h exp=5555", bus.D_Instr); end
    total++; if (bus.stall_cnt !== exp_cnt) begin bad++; $display("FAIL hz_r0_cnt act=%h exp=%h", bus.stall_cnt, exp_cnt); end
  endtask

  task automatic test_sw();
    // non-store with rd=5: src2 is [3:0]=0, so rd=5 is not a source
    drive(16'h0540, 16'h0008, 1'b0, 1'b0, 4'd0);
    step();
    drive(16'h9540, 16'h000A, 1'b0, 1'b1, 4'd5);
    #1;
    total++; if (bus.pc_wen !== 1'b1) begin bad++; $display("FAIL nonsw_rd_pcwen act=%b exp=1", bus.pc_wen); end
    bus.X_MemRead = 1'b0;
    step();
    total++; if (bus.D_Instr !== 16'h9540) begin bad++; $display("FAIL sw_load act=%h exp=9540", bus.D_Instr); end
    drive(16'h6666, 16'h000C, 1'b0, 1'b1, 4'd5);
    #1;
    total++; if (bus.pc_wen !== 1'b0) begin bad++; $display("FAIL sw_rd_pcwen act=%b exp=0", bus.pc_wen); end
    total++; if (bus.id_ex_bubble !== 1'b1) begin bad++; $display("FAIL sw_rd_bubble act=%b exp=1", bus.id_ex_bubble); end
    bus.X_Destination = 4'd4;
    #1;
    total++; if (bus.pc_wen !== 1'b0) begin bad++; $display("FAIL sw_rs_pcwen act=%b exp=0", bus.pc_wen); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    total++; if (bus.stall_cnt !== exp_cnt) begin bad++; $display("FAIL sw_cnt act=%h exp=%h", bus.stall_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    // D_Instr=9540 still held; hazard on rd=5 plus branch
    drive(16'h7777, 16'h00AA, 1'b1, 1'b1, 4'd5);
    #1;
    total++; if (bus.pc_wen !== 1'b1) begin bad++; $display("FAIL fl_pcwen act=%b exp=1", bus.pc_wen); end
    total++; if (bus.id_ex_bubble !== 1'b0) begin bad++; $display("FAIL fl_bubble act=%b exp=0", bus.id_ex_bubble); end
    step();
    total++; if (bus.D_valid !== 1'b0) begin bad++; $display("FAIL fl_valid act=%b exp=0", bus.D_valid); end
    total++; if (bus.D_Instr !== 16'h0000) begin bad++; $display("FAIL fl_instr act=%h exp=0000", bus.D_Instr); end
    total++; if (bus.D_Nxt_Pc !== 16'h00AA) begin bad++; $display("FAIL fl_pc act=%h exp=00aa", bus.D_Nxt_Pc); end
    total++; if (bus.stall_cnt !== exp_cnt) begin bad++; $display("FAIL fl_cnt act=%h exp=%h", bus.stall_cnt, exp_cnt); end
    // invalid decode slot never hazards
    bus.Br_taken = 1'b0;
    #1;
    total++; if (bus.pc_wen !== 1'b1) begin bad++; $display("FAIL fl_bubble_nohz act=%b exp=1", bus.pc_wen); end
    bus.X_MemRead = 1'b0;
  endtask

  task automatic test_halt();
    drive(16'hF000, 16'h0010, 1'b0, 1'b0, 4'd0);
    step();
    total++; if (bus.D_Instr !== 16'hF000) begin bad++; $display("FAIL hlt_instr act=%h exp=f000", bus.D_Instr); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL hlt_early act=%b exp=0", bus.halted); end
    bus.F_Instr = 16'h1111; bus.F_Nxt_Pc = 16'h0012;
    step();
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL hlt_halted act=%b exp=1", bus.halted); end
    total++; if (bus.pc_wen !== 1'b0) begin bad++; $display("FAIL hlt_pcwen act=%b exp=0", bus.pc_wen); end
    total++; if (bus.D_valid !== 1'b0) begin bad++; $display("FAIL hlt_valid act=%b exp=0", bus.D_valid); end
    total++; if (bus.id_ex_bubble !== 1'b1) begin bad++; $display("FAIL hlt_bubble act=%b exp=1", bus.id_ex_bubble); end
    total++; if (bus.D_Instr !== 16'h0000) begin bad++; $display("FAIL hlt_nop act=%h exp=0000", bus.D_Instr); end
    drive(16'h2222, 16'h0040, 1'b1, 1'b1, 4'd1);
    step();
    bus.Br_taken = 1'b0;
    step();
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL hlt_stay act=%b exp=1", bus.halted); end
    total++; if (bus.D_Instr !== 16'h0000) begin bad++; $display("FAIL hlt_hold act=%h exp=0000", bus.D_Instr); end
    total++; if (bus.stall_cnt !== exp_cnt) begin bad++; $display("FAIL hlt_cnt act=%h exp=%h", bus.stall_cnt, exp_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL hlt_arst act=%b exp=0", bus.halted); end
    total++; if (bus.pc_wen !== 1'b1) begin bad++; $display("FAIL hlt_arst_pcwen act=%b exp=1", bus.pc_wen); end
    total++; if (bus.stall_cnt !== 16'h0000) begin bad++; $display("FAIL hlt_arst_cnt act=%h exp=0000", bus.stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 16'h0000;
  endtask

  task automatic test_saturate();
    drive(16'h0312, 16'h0002, 1'b0, 1'b0, 4'd0);
    step();
    drive(16'h4444, 16'h0004, 1'b0, 1'b1, 4'd1);
    repeat (65534) step();
    total++; if (bus.stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre act=%h exp=fffe", bus.stall_cnt); end
    step();
    total++; if (bus.stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_max act=%h exp=ffff", bus.stall_cnt); end
    repeat (3) step();
    total++; if (bus.stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold act=%h exp=ffff", bus.stall_cnt); end
    total++; if (bus.D_Instr !== 16'h0312) begin bad++; $display("FAIL sat_instr act=%h exp=0312", bus.D_Instr); end
    // reset in the middle of a stall
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.stall_cnt !== 16'h0000) begin bad++; $display("FAIL sat_arst_cnt act=%h exp=0000", bus.stall_cnt); end
    total++; if (bus.D_valid !== 1'b0) begin bad++; $display("FAIL sat_arst_valid act=%b exp=0", bus.D_valid); end
    total++; if (bus.id_ex_bubble !== 1'b0) begin bad++; $display("FAIL sat_arst_bubble act=%b exp=0", bus.id_ex_bubble); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_cnt = 16'h0000;
    test_reset();
    test_load();
    test_hazard();
    test_sw();
    test_flush();
    test_halt();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch/decode boundary register. It sits directly upstream of the ID/EX pipeline register and feeds it the decoded-stage instruction and next PC.
- Owns the load-use hazard check, branch flush, HLT freeze FSM, PC write-enable and ID/EX bubble request.
- 16-bit WISC-style ISA: opcode in instr[15:12], rd in [11:8], rs in [7:4], rt in [3:0].

Parameters:
- HLT_OP, 4'hF, opcode that freezes fetch.
- LW_OP, 4'h8, load opcode (X-side hazard source; informational, X_MemRead is authoritative).
- SW_OP, 4'h9, store opcode (reads [11:8] as a source).
- NOP_INSTR, 16'h0000, instruction injected on flush/reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  async active-low reset.
- F_Instr  in  16  instruction from instruction memory.
- F_Nxt_Pc  in  16  PC+2 from fetch.
- Br_taken  in  1  branch/BR resolved taken in decode; flush request.
- X_MemRead  in  1  instruction currently in EX is a load.
- X_Destination  in  4  rd of the instruction in EX.
- D_Instr  out  16  registered instruction to decode.
- D_Nxt_Pc  out  16  registered PC+2 to decode.
- D_valid  out  1  D_Instr is a real instruction (not a bubble).
- pc_wen  out  1  PC register write enable.
- id_ex_bubble  out  1  force zero control signals into ID/EX this cycle.
- halted  out  1  FSM in HALT.
- stall_cnt  out  16  saturating count of load-use stall cycles.

Behaviour:
- Reset (async, rst_n=0):
  - D_Instr=NOP_INSTR, D_Nxt_Pc=0, D_valid=0, state=RUN, stall_cnt=0.
  - Comb outputs under reset: pc_wen=1, id_ex_bubble=0, halted=0.
- Source regs of D_Instr:
  - src1=[7:4].
  - src2=[11:8] when opcode in {SW_OP, 4'hA, 4'hB}, else [3:0].
- Hazard (comb): hz = D_valid & X_MemRead & (X_Destination!=0) & (X_Destination==src1 | X_Destination==src2). R0 is never a hazard.
- Priority per cycle: HALT state > Br_taken > hz > normal.
- RUN, normal: IF/ID loads F_Instr/F_Nxt_Pc, D_valid<=1, pc_wen=1, id_ex_bubble=0.
- RUN, Br_taken:
  - D_Instr<=NOP_INSTR, D_valid<=0, D_Nxt_Pc<=F_Nxt_Pc, pc_wen=1 (PC takes target).
  - Current decode instruction is not squashed; id_ex_bubble=0.
  - Flush overrides a simultaneous hz; the stall is not counted.
- RUN, hz:
  - IF/ID holds, pc_wen=0, id_ex_bubble=1, stall_cnt+=1 (saturates at 16'hFFFF).
  - Stall lasts exactly one cycle, because the bubble clears X_MemRead next cycle.
- RUN -> HALT: at the clock edge where D_valid=1, D_Instr[15:12]==HLT_OP, Br_taken=0 and hz=0.
  - HLT passes to ID/EX normally that cycle.
  - IF/ID then loads NOP_INSTR with D_valid=0.
- HALT:
  - pc_wen=0, IF/ID holds NOP, D_valid=0, id_ex_bubble=1, halted=1.
  - Br_taken and hz are ignored; stall_cnt is frozen.
  - Exit only via reset.
- Reset asserted mid-stall or mid-halt: immediate return to reset values; no partial state survives.
- Latency: F_Instr to D_Instr is 1 cycle when not stalled.

Test Plan:
- Reset then F_Instr=16'h1234, F_Nxt_Pc=16'h0002 for one edge -> D_Instr=16'h1234, D_Nxt_Pc=2, D_valid=1, pc_wen=1.
- D_Instr=16'h0312 (ADD r3,r1,r2), X_MemRead=1, X_Destination=1 -> pc_wen=0, id_ex_bubble=1, D_Instr held one cycle, stall_cnt 0->1. Repeat with X_Destination=0 -> no stall.
- SW D_Instr=16'h9540, X_MemRead=1, X_Destination=5 -> stall asserted (src2=[11:8]=5).
- Br_taken=1 concurrent with hz=1 -> next D_valid=0, D_Instr=0, pc_wen=1, stall_cnt unchanged.
- F_Instr=16'hF000 -> one cycle later D_Instr=F000; next edge halted=1, pc_wen=0, D_valid=0; toggling Br_taken/F_Instr has no effect; rst_n low -> halted=0 asynchronously.
- Force 65536 stall cycles -> stall_cnt stays at 16'hFFFF.
